reg_file: RTL and testbench



---
 rtl/reg_file.sv | 68 ++++++
 tb/tb_reg_file.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Configuration/data register file; REG0-REG3 exported continuously.
// Optional REGFILE_RDDATA_CLR_EN: RdData clears on cycles without a read.
module reg_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDR  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WrEn,
  input  logic             RdEn,
  input  logic [ADDR-1:0]  Address,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] RdData,
  output logic             RdData_Valid,
  output logic [WIDTH-1:0] REG0,
  output logic [WIDTH-1:0] REG1,
  output logic [WIDTH-1:0] REG2,
  output logic [WIDTH-1:0] REG3
);

  logic [WIDTH-1:0] regs [0:DEPTH-1];
  logic             wr_ok;
  logic             rd_ok;
  logic             in_range;

  function automatic logic [WIDTH-1:0] rst_val(input int i);
    case (i)
      2:       rst_val = WIDTH'(8'h81);
      3:       rst_val = WIDTH'(8'h20);
      default: rst_val = '0;
    endcase
  endfunction

  // Simultaneous requests are dropped rather than prioritised
  assign wr_ok    = WrEn & ~RdEn;
  assign rd_ok    = RdEn & ~WrEn;
  assign in_range = (32'(Address) < DEPTH);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= rst_val(i);
      end
      RdData       <= '0;
      RdData_Valid <= 1'b0;
    end else begin
      RdData_Valid <= rd_ok;
      if (rd_ok) begin
        RdData <= in_range ? regs[Address] : '0;
      end
`ifdef REGFILE_RDDATA_CLR_EN
      else begin
        RdData <= '0;
      end
`endif
      if (wr_ok && in_range) begin
        regs[Address] <= WrData;
      end
    end
  end

  assign REG0 = regs[0];
  assign REG1 = regs[1];
  assign REG2 = regs[2];
  assign REG3 = regs[3];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_reg_file;

  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         WrEn;
  logic         RdEn;
  logic [A-1:0] Address;
  logic [W-1:0] WrData;
  logic [W-1:0] RdData;
  logic         RdData_Valid;
  logic [W-1:0] REG0, REG1, REG2, REG3;

  reg_file #(.WIDTH(W), .DEPTH(D), .ADDR(A)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .REG0         (REG0),
    .REG1         (REG1),
    .REG2         (REG2),
    .REG3         (REG3)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [W-1:0] m_mem [D];
  logic [W-1:0] m_rd;
  logic         m_v;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [3:0] addr;
    logic [7:0] wd;
    bit         exp_v;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_mem[2] = 8'h81;
    m_mem[3] = 8'h20;
    m_rd = '0;
    m_v  = 1'b0;
  endtask

  task automatic model_edge(input bit wr, input bit rd,
                            input int addr, input logic [7:0] wd);
    m_v = rd && !wr;
    if (m_v) m_rd = (addr < D) ? m_mem[addr] : '0;
`ifdef REGFILE_RDDATA_CLR_EN
    else m_rd = '0;
`endif
    if (wr && !rd && addr < D) m_mem[addr] = wd;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(RdData_Valid), 32'(m_v));
    chk({tag, ".rddata"}, 32'(RdData), 32'(m_rd));
    chk({tag, ".reg0"}, 32'(REG0), 32'(m_mem[0]));
    chk({tag, ".reg1"}, 32'(REG1), 32'(m_mem[1]));
    chk({tag, ".reg2"}, 32'(REG2), 32'(m_mem[2]));
    chk({tag, ".reg3"}, 32'(REG3), 32'(m_mem[3]));
  endtask

  task automatic step(input bit wr, input bit rd,
                      input logic [3:0] addr, input logic [7:0] wd,
                      input string tag);
    WrEn    = wr;
    RdEn    = rd;
    Address = addr;
    WrData  = wd;
    @(posedge CLK);
    #1;
    model_edge(wr, rd, int'(addr), wd);
    check_all(tag);
  endtask

  task automatic add(input bit wr, input bit rd, input logic [3:0] addr,
                     input logic [7:0] wd, input bit ev,
                     input logic [7:0] er);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wd = wd;
    v.exp_v = ev; v.exp_rd = er;
    vecs.push_back(v);
  endtask

  task automatic async_reset(input string tag);
    #2 RST = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 RST = 1'b0;
  endtask

  initial begin
    logic [7:0] idle_exp;
    RST = 1'b1;
    WrEn = 1'b0;
    RdEn = 1'b0;
    Address = '0;
    WrData = '0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge CLK);
    #1 RST = 1'b0;

    // Directed table: reset reads, writes, readback, dropped request
    add(0, 1, 4'd2, 8'h00, 1, 8'h81);
    add(0, 1, 4'd3, 8'h00, 1, 8'h20);
    add(0, 1, 4'd0, 8'h00, 1, 8'h00);
    add(1, 0, 4'd0, 8'hAA, 0, 8'h00);
    add(1, 0, 4'd1, 8'h55, 0, 8'h00);
    add(1, 0, 4'd4, 8'hFF, 0, 8'h00);
    add(1, 0, 4'd2, 8'h12, 0, 8'h00);
    add(1, 0, 4'd3, 8'h34, 0, 8'h00);
    add(0, 1, 4'd2, 8'h00, 1, 8'h12);
    add(0, 1, 4'd3, 8'h00, 1, 8'h34);
    add(1, 1, 4'd5, 8'h77, 0, 8'h00);
    add(0, 1, 4'd5, 8'h00, 1, 8'h00);
    add(1, 0, 4'd6, 8'h3C, 0, 8'h00);
    add(0, 1, 4'd6, 8'h00, 1, 8'h3C);
    // Back-to-back reads with RdEn held high
    add(0, 1, 4'd0, 8'h00, 1, 8'hAA);
    add(0, 1, 4'd1, 8'h00, 1, 8'h55);
    add(0, 1, 4'd4, 8'h00, 1, 8'hFF);

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd,
           $sformatf("tv%0d", i));
      chk($sformatf("tv%0d.exp_valid", i), 32'(RdData_Valid),
          32'(vecs[i].exp_v));
      if (vecs[i].exp_v)
        chk($sformatf("tv%0d.exp_rd", i), 32'(RdData),
            32'(vecs[i].exp_rd));
    end

    // Idle after the last read: hold or clear
`ifdef REGFILE_RDDATA_CLR_EN
    idle_exp = 8'h00;
`else
    idle_exp = 8'hFF;
`endif
    step(0, 0, 4'd0, 8'h00, "idle");
    chk("idle.rddata", 32'(RdData), 32'(idle_exp));
    chk("idle.valid", 32'(RdData_Valid), 32'd0);

    // Write then read same address on the very next edge
    step(1, 0, 4'd7, 8'hC3, "wr7");
    step(0, 1, 4'd7, 8'h00, "rd7");
    chk("rd_after_wr", 32'(RdData), 32'hC3);

    // Asynchronous reset between edges while a read is valid
    step(1, 0, 4'd2, 8'h99, "wr99");
    chk("reg2_99", 32'(REG2), 32'h99);
    step(0, 1, 4'd0, 8'h00, "rd_pre_rst");
    async_reset("async_rst");
    chk("async_reg2", 32'(REG2), 32'h81);
    chk("async_valid", 32'(RdData_Valid), 32'd0);
    chk("async_rddata", 32'(RdData), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 60) == 0) begin
        async_reset($sformatf("rnd_rst%0d", i));
      end else begin
        step(1'($urandom), 1'($urandom),
             ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3))
                                         : 4'($urandom),
             8'($urandom), $sformatf("rnd%0d", i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
